// File: rtl/lcd_pkg.sv
// Shared types, init table and timing helpers for the HD44780 4-bit sequencer.
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_PWR_WAIT,
        ST_INIT_SEND,
        ST_INIT_WAIT,
        ST_GAP,
        ST_READY,
        ST_HI_SEND,
        ST_HI_WAIT,
        ST_LO_SEND,
        ST_LO_WAIT
    } state_t;

    typedef struct packed {
        logic [3:0]  nibble;
        logic [15:0] delay_us;
    } init_step_t;

    localparam int unsigned INIT_LEN   = 12;
    localparam int unsigned PWR_US     = 15000;
    localparam int unsigned HI_US      = 1;
    localparam int unsigned LO_US      = 40;
    localparam int unsigned LO_LONG_US = 1640;

    // Power-on 4-bit handshake, then function set 0x28, display on 0x0C,
    // clear 0x01 and entry mode 0x06, each byte as two nibbles.
    localparam init_step_t INIT_TABLE [INIT_LEN] = '{
        '{4'h3, 16'd4100},
        '{4'h3, 16'd100},
        '{4'h3, 16'd40},
        '{4'h2, 16'd40},
        '{4'h2, 16'd1},
        '{4'h8, 16'd40},
        '{4'h0, 16'd1},
        '{4'hC, 16'd40},
        '{4'h0, 16'd1},
        '{4'h1, 16'd1640},
        '{4'h0, 16'd1},
        '{4'h6, 16'd40}
    };

    // Microseconds to clock cycles, rounded up, never below one cycle.
    function automatic longint unsigned us_to_cycles(input longint unsigned freq,
                                                     input longint unsigned us);
        longint unsigned c;
        c = (freq * us + 64'd999_999) / 64'd1_000_000;
        if (c == 64'd0) c = 64'd1;
        return c;
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Init step index -> nibble and post-nibble delay in cycles.
module lcd_init_rom
    import lcd_pkg::*;
#(
    parameter int unsigned FREQ    = 50_000_000,
    parameter int unsigned DELAY_W = 21
) (
    input  logic [3:0]         i_step,
    output logic [3:0]         o_nibble,
    output logic [DELAY_W-1:0] o_delay
);

    logic [DELAY_W-1:0] w_cycles [INIT_LEN];

    for (genvar g = 0; g < INIT_LEN; g++) begin : g_cycles
        assign w_cycles[g] = DELAY_W'(us_to_cycles(64'(FREQ), 64'(INIT_TABLE[g].delay_us)));
    end

    // Table lookup; out-of-range steps read as a harmless 1-cycle zero nibble.
    always_comb begin
        o_nibble = '0;
        o_delay  = DELAY_W'(1);
        if (i_step < 4'(INIT_LEN)) begin
            o_nibble = INIT_TABLE[i_step].nibble;
            o_delay  = w_cycles[i_step];
        end
    end

endmodule

// File: rtl/lcd_sequencer.sv
// Power-on init and byte-write sequencer feeding the lcd_transfer nibble engine.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned FREQ    = 50_000_000,
    parameter int unsigned DELAY_W = 21
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               wr_valid,
    input  logic [7:0]         wr_data,
    input  logic               wr_rs,
    output logic               wr_ready,
    output logic               init_done,
    output logic               send_cmd,
    output logic [3:0]         cmd_nibble,
    output logic               cmd_rs,
    output logic [DELAY_W-1:0] cmd_delay,
    input  logic               cmd_done
);

    localparam logic [DELAY_W-1:0] PWR_LAST    = DELAY_W'(us_to_cycles(64'(FREQ), 64'(PWR_US)) - 64'd1);
    localparam logic [DELAY_W-1:0] HI_CYC      = DELAY_W'(us_to_cycles(64'(FREQ), 64'(HI_US)));
    localparam logic [DELAY_W-1:0] LO_CYC      = DELAY_W'(us_to_cycles(64'(FREQ), 64'(LO_US)));
    localparam logic [DELAY_W-1:0] LO_LONG_CYC = DELAY_W'(us_to_cycles(64'(FREQ), 64'(LO_LONG_US)));

    // The power-on wait is the longest delay; if it fits, every other one does.
    if (us_to_cycles(64'(FREQ), 64'(PWR_US)) >= (64'd1 << DELAY_W)) begin : g_delay_check
        $error("lcd_sequencer: DELAY_W too narrow for derived delays");
    end

    state_t             r_state, w_next;
    logic [DELAY_W-1:0] r_cnt, w_cnt;
    logic [3:0]         r_step, w_step;
    logic               r_init_done, w_set_done;
    logic [7:0]         r_byte;
    logic               r_byte_rs, w_capture;
    logic               r_send_cmd, w_load;
    logic [3:0]         r_nibble, w_nibble;
    logic               r_rs, w_rs;
    logic [DELAY_W-1:0] r_delay, w_delay;
    logic [3:0]         w_rom_nibble;
    logic [DELAY_W-1:0] w_rom_delay;

    lcd_init_rom #(
        .FREQ    (FREQ),
        .DELAY_W (DELAY_W)
    ) u_rom (
        .i_step   (r_step),
        .o_nibble (w_rom_nibble),
        .o_delay  (w_rom_delay)
    );

    // Next state plus the nibble/rs/delay to launch when entering a SEND state.
    // READY itself provides the one-cycle gap after the last init nibble and after
    // a low nibble, so a pending write launches exactly two cycles after cmd_done.
    always_comb begin
        w_next     = r_state;
        w_cnt      = r_cnt;
        w_step     = r_step;
        w_set_done = 1'b0;
        w_capture  = 1'b0;
        w_load     = 1'b0;
        w_nibble   = r_nibble;
        w_rs       = r_rs;
        w_delay    = r_delay;
        case (r_state)
            ST_PWR_WAIT: begin
                if (r_cnt == PWR_LAST) begin
                    w_next   = ST_INIT_SEND;
                    w_cnt    = '0;
                    w_load   = 1'b1;
                    w_nibble = w_rom_nibble;
                    w_rs     = 1'b0;
                    w_delay  = w_rom_delay;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_INIT_SEND: w_next = ST_INIT_WAIT;
            ST_INIT_WAIT: begin
                if (cmd_done) begin
                    if (r_step == 4'(INIT_LEN - 1)) begin
                        w_next     = ST_READY;
                        w_set_done = 1'b1;
                    end else begin
                        w_next = ST_GAP;
                        w_step = r_step + 4'd1;
                    end
                end
            end
            ST_GAP: begin
                w_load = 1'b1;
                if (!r_init_done) begin
                    w_next   = ST_INIT_SEND;
                    w_nibble = w_rom_nibble;
                    w_rs     = 1'b0;
                    w_delay  = w_rom_delay;
                end else begin
                    w_next   = ST_LO_SEND;
                    w_nibble = r_byte[3:0];
                    w_rs     = r_byte_rs;
                    w_delay  = (!r_byte_rs && r_byte <= 8'h03) ? LO_LONG_CYC : LO_CYC;
                end
            end
            ST_READY: begin
                if (wr_valid) begin
                    w_next    = ST_HI_SEND;
                    w_capture = 1'b1;
                    w_load    = 1'b1;
                    w_nibble  = wr_data[7:4];
                    w_rs      = wr_rs;
                    w_delay   = HI_CYC;
                end
            end
            ST_HI_SEND: w_next = ST_HI_WAIT;
            ST_HI_WAIT: if (cmd_done) w_next = ST_GAP;
            ST_LO_SEND: w_next = ST_LO_WAIT;
            ST_LO_WAIT: if (cmd_done) w_next = ST_READY;
            default:    w_next = ST_PWR_WAIT;
        endcase
    end

    // State, counters, captured byte and held command outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_PWR_WAIT;
            r_cnt       <= '0;
            r_step      <= '0;
            r_init_done <= 1'b0;
            r_byte      <= '0;
            r_byte_rs   <= 1'b0;
            r_send_cmd  <= 1'b0;
            r_nibble    <= '0;
            r_rs        <= 1'b0;
            r_delay     <= '0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt;
            r_step     <= w_step;
            r_send_cmd <= w_load;
            if (w_set_done) r_init_done <= 1'b1;
            if (w_capture) begin
                r_byte    <= wr_data;
                r_byte_rs <= wr_rs;
            end
            if (w_load) begin
                r_nibble <= w_nibble;
                r_rs     <= w_rs;
                r_delay  <= w_delay;
            end
        end
    end

    assign wr_ready   = (r_state == ST_READY);
    assign init_done  = r_init_done;
    assign send_cmd   = r_send_cmd;
    assign cmd_nibble = r_nibble;
    assign cmd_rs     = r_rs;
    assign cmd_delay  = r_delay;

    // A launch is always a single-cycle pulse.
    a_send_pulse: assert property (@(posedge CLK) disable iff (!RST_N) r_send_cmd |=> !r_send_cmd);

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer: transfer-queue model plus an lcd_transfer-like responder.
module tb_lcd_sequencer;

    localparam int unsigned FREQ = 1_000_000;
    localparam int DW = 21;
    localparam int K_REL = 0, K_TIGHT = 1, K_LOOSE = 2;

    typedef struct {
        int nib;
        int rs;
        int dly;
        int kind;
    } xfer_t;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          wr_valid = 1'b0;
    logic [7:0]    wr_data = '0;
    logic          wr_rs = 1'b0;
    logic          wr_ready, init_done, send_cmd, cmd_rs;
    logic [3:0]    cmd_nibble;
    logic [DW-1:0] cmd_delay;
    logic          cmd_done = 1'b0;

    int total = 0, bad = 0;
    int cyc = 0, rel_cyc = 0, m_last_done = -100;
    int rem = 0, acc_cnt = 0, m_init_cnt = 0;
    bit m_init_done = 0;
    int h_nib, h_rs, h_dly;
    xfer_t q[$];
    xfer_t log_q[$];

    int init_nib [12] = '{3, 3, 3, 2, 2, 8, 0, 12, 0, 1, 0, 6};
    int init_us  [12] = '{4100, 100, 40, 40, 1, 40, 1, 40, 1, 1640, 1, 40};

    lcd_sequencer #(
        .FREQ    (FREQ),
        .DELAY_W (DW)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_rs      (wr_rs),
        .wr_ready   (wr_ready),
        .init_done  (init_done),
        .send_cmd   (send_cmd),
        .cmd_nibble (cmd_nibble),
        .cmd_rs     (cmd_rs),
        .cmd_delay  (cmd_delay),
        .cmd_done   (cmd_done)
    );

    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc = cyc + 1;
    end

    function automatic int cycles_of(input int us);
        longint c;
        c = (longint'(FREQ) * us + 999_999) / 1_000_000;
        return (c < 1) ? 1 : int'(c);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        xfer_t e;
        q.delete();
        m_init_done = 0;
        m_init_cnt  = 0;
        m_last_done = -100;
        for (int i = 0; i < 12; i++) begin
            e.nib = init_nib[i]; e.rs = 0; e.dly = cycles_of(init_us[i]);
            e.kind = (i == 0) ? K_REL : K_TIGHT;
            q.push_back(e);
        end
    endtask

    // Model compare plus responder: cmd_done arrives delay+2 cycles after send_cmd.
    initial forever begin
        xfer_t e;
        @(negedge CLK);
        if (!RST_N) begin
            rem = 0;
            cmd_done = 1'b0;
        end else begin
            chk("init_done", init_done, m_init_done);
            chk("wr_ready", wr_ready, m_init_done && q.size() == 0 && rem == 0);
            if (send_cmd) begin
                if (rem != 0 || q.size() == 0) begin
                    chk("unexpected_send", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("nibble", cmd_nibble, e.nib);
                    chk("rs", cmd_rs, e.rs);
                    chk("delay", cmd_delay, e.dly);
                    if (e.kind == K_REL) chk("pwr_wait_cycles", cyc - rel_cyc, cycles_of(15000));
                    else if (e.kind == K_TIGHT) chk("gap_exact2", cyc - m_last_done, 2);
                    else chk("gap_min2", (cyc - m_last_done) >= 2, 1);
                end
                e.nib = cmd_nibble; e.rs = cmd_rs; e.dly = int'(cmd_delay); e.kind = 0;
                log_q.push_back(e);
                h_nib = cmd_nibble; h_rs = cmd_rs; h_dly = int'(cmd_delay);
            end else if (rem > 0) begin
                chk("hold_nibble", cmd_nibble, h_nib);
                chk("hold_rs", cmd_rs, h_rs);
                chk("hold_delay", cmd_delay, h_dly);
            end
            cmd_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    cmd_done = 1'b1;
                    m_last_done = cyc;
                    if (!m_init_done) begin
                        m_init_cnt++;
                        if (m_init_cnt == 12) m_init_done = 1;
                    end
                end
            end else if (send_cmd) begin
                rem = int'(cmd_delay) + 2;
            end
            if (wr_valid && wr_ready) begin
                e.nib = wr_data[7:4]; e.rs = wr_rs; e.dly = cycles_of(1);
                e.kind = (cyc == m_last_done + 1) ? K_TIGHT : K_LOOSE;
                q.push_back(e);
                e.nib = wr_data[3:0];
                e.dly = (!wr_rs && wr_data <= 8'h03) ? cycles_of(1640) : cycles_of(40);
                e.kind = K_TIGHT;
                q.push_back(e);
                acc_cnt++;
            end
        end
    end

    task automatic wait_acc(input int start);
        for (int i = 0; i < 30000 && acc_cnt == start; i++) @(posedge CLK);
        if (acc_cnt == start) chk("accept_timeout", 0, 1);
        #2;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30000 && !(m_init_done && q.size() == 0 && rem == 0 && !cmd_done); i++)
            @(posedge CLK);
        if (!(m_init_done && q.size() == 0 && rem == 0 && !cmd_done)) chk("idle_timeout", 0, 1);
        #2;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic rs);
        int s;
        s = acc_cnt;
        wr_valid = 1'b1; wr_data = d; wr_rs = rs;
        wait_acc(s);
        wr_valid = 1'b0;
    endtask

    task automatic lit(input string nm, input int idx, input int nib, input int rs, input int dly);
        if (idx >= log_q.size()) begin
            chk({nm, "_missing"}, log_q.size(), idx + 1);
        end else begin
            chk({nm, "_nib"}, log_q[idx].nib, nib);
            chk({nm, "_rs"}, log_q[idx].rs, rs);
            chk({nm, "_dly"}, log_q[idx].dly, dly);
        end
    endtask

    task automatic reset_zero_check(input string nm);
        chk({nm, "_send"}, send_cmd, 0);
        chk({nm, "_nib"}, cmd_nibble, 0);
        chk({nm, "_rs"}, cmd_rs, 0);
        chk({nm, "_dly"}, cmd_delay, 0);
        chk({nm, "_ready"}, wr_ready, 0);
        chk({nm, "_idone"}, init_done, 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        repeat (3) @(negedge CLK);
        reset_zero_check("por");
        model_reset();
        // Byte pending during the whole init: must stall until init_done.
        wr_valid = 1'b1; wr_data = 8'h48; wr_rs = 1'b1;
        @(negedge CLK); #3;
        RST_N = 1'b1;
        rel_cyc = cyc;
        wait_acc(0);
        wr_valid = 1'b0;
        wait_idle();
        lit("init0", 0, 3, 0, 4100);
        lit("init9", 9, 1, 0, 1640);
        lit("init11", 11, 6, 0, 40);
        lit("early_hi", 12, 4, 1, 1);
        lit("early_lo", 13, 8, 1, 40);

        write_byte(8'h41, 1'b1); wait_idle();
        lit("b41_hi", 14, 4, 1, 1);
        lit("b41_lo", 15, 1, 1, 40);

        write_byte(8'h01, 1'b0); wait_idle();
        write_byte(8'h04, 1'b0); wait_idle();
        lit("clr_lo", 17, 1, 0, 1640);
        lit("b04_lo", 19, 4, 0, 40);

        // Back-to-back bytes with wr_valid held high.
        s = acc_cnt;
        wr_valid = 1'b1; wr_data = 8'h01; wr_rs = 1'b1;
        wait_acc(s);
        wr_data = 8'h7E; wr_rs = 1'b1;
        wait_acc(s + 1);
        wr_data = 8'h03; wr_rs = 1'b0;
        wait_acc(s + 2);
        wr_valid = 1'b0;
        wait_idle();
        lit("b2b_0_lo", 21, 1, 1, 40);
        lit("b2b_1_hi", 22, 7, 1, 1);
        lit("b2b_2_lo", 25, 3, 0, 1640);

        // Asynchronous reset while the high nibble is in flight.
        write_byte(8'h55, 1'b1);
        for (int i = 0; i < 100 && rem == 0; i++) @(posedge CLK);
        chk("hi_in_flight", rem > 0, 1);
        #3;
        RST_N = 1'b0;
        #1;
        reset_zero_check("midrst");
        model_reset();
        @(negedge CLK); #3;
        RST_N = 1'b1;
        rel_cyc = cyc;
        wait_idle();
        lit("replay0", 27, 3, 0, 4100);
        write_byte(8'h03, 1'b0); wait_idle();
        lit("home_lo", 40, 3, 0, 1640);
        chk("log_len", log_q.size(), 41);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
